// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM and a single-entry
// valid/ready holding register. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx #(
  parameter real    CLK_FREQ  = 50_000_000.0,
  parameter integer BAUD_RATE = 3_000_000
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_error
);

  localparam int CPB  = int'(CLK_FREQ / BAUD_RATE);  // int' of a real rounds to nearest
  localparam int HALF = CPB / 2;

`ifdef UART_RX_MAJORITY_EN
  localparam int MIN_CPB    = 8;
  localparam int START_LAST = HALF;      // decide at mid+1 once all three samples exist
`else
  localparam int MIN_CPB    = 4;
  localparam int START_LAST = HALF - 1;
`endif

  localparam logic [15:0] START_END = 16'(START_LAST);
  localparam logic [15:0] BIT_END   = 16'(CPB - 1);

  generate
    if (CPB < MIN_CPB || CPB > 65536) begin : g_bad_cfg
      $error("uart_rx: cycles per bit (%0d) out of range", CPB);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        brk, brk_n;
  logic [7:0]  data_n;
  logic        valid_n, error_n;

  logic sync1, rs, rs_q1, samp;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
      rs_q1 <= 1'b1;
    end else begin
      sync1 <= rxd;
      rs    <= sync1;
      rs_q1 <= rs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rs_q2;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rs_q2 <= 1'b1;
    else        rs_q2 <= rs_q1;
  end

  assign samp = (rs & rs_q1) | (rs & rs_q2) | (rs_q1 & rs_q2);
`else
  assign samp = rs;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      brk      <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      brk      <= brk_n;
      rx_data  <= data_n;
      rx_valid <= valid_n;
      rx_error <= error_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    shreg_n = shreg;
    brk_n   = brk;
    data_n  = rx_data;
    valid_n = rx_valid & ~rx_ready;
    error_n = rx_error;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rs_q1 && !rs) state_n = START;
      end
      START: begin
        if (cnt == START_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = samp ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shreg_n = {samp, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (brk) begin
          // Line held low after a bad stop bit: wait for it to go idle before rearming.
          cnt_n = '0;
          if (rs) begin
            brk_n   = 1'b0;
            state_n = IDLE;
          end
        end else if (cnt == BIT_END) begin
          cnt_n = '0;
          if (!samp) begin
            error_n = 1'b1;
            brk_n   = 1'b1;
          end else begin
            state_n = IDLE;
            if (rx_valid && !rx_ready) begin
              error_n = 1'b1;
            end else begin
              data_n  = shreg;
              valid_n = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks plus a byte scoreboard checked on
// every rx_valid & rx_ready handshake.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB  = 17;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_error;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  uart_rx #(.CLK_FREQ(50_000_000.0), .BAUD_RATE(3_000_000)) dut (
    .clk(clk), .arstn(arstn), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted byte must match the oldest expected one.
  always @(negedge clk) begin
    if (arstn && rx_valid && rx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, required no byte", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL byte_data: got %02h, required %02h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, and the stop bit; toggle alternates 16/18 clk bits.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit toggle);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      tick(toggle ? ((i % 2 == 1) ? 18 : 16) : CPB);
    end
  endtask

  task automatic test_reset;
    arstn = 1'b0;
    tick(3);
    checks++;
    if ({rx_data, rx_valid, rx_busy, rx_error} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %03h, required 000", {rx_data, rx_valid, rx_busy, rx_error});
    end
    arstn = 1'b1;
    tick(5);
  endtask

  task automatic test_basic;
    int busy_cnt = 0;
    int w = 0;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(negedge clk);
        while (!rx_busy && w < 40) begin
          @(negedge clk);
          w++;
        end
        while (rx_busy && busy_cnt < 400) begin
          busy_cnt++;
          @(negedge clk);
        end
        checks++;
        if (rx_valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_when_busy_falls: got %b, required 1", rx_valid);
        end
        checks++;
        if (busy_cnt != 161) begin
          errors++;
          $display("FAIL busy_length: got %0d, required 161", busy_cnt);
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_one_cycle: got %b, required 0", rx_valid);
        end
      end
    join
    tick(5);
    checks++;
    if (rx_error !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_done: error=%b pending=%0d, required 0 and 0", rx_error, exp_q.size());
    end
  endtask

  task automatic test_glitch;
    int  bc = 0;
    bit  seen_valid = 0;
    fork
      begin
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
      end
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (rx_busy)  bc++;
        if (rx_valid) seen_valid = 1;
      end
    join
    checks++;
    if (bc < 1 || bc > HALF + 1) begin
      errors++;
      $display("FAIL glitch_busy_pulse: got %0d cycles, required 1..%0d", bc, HALF + 1);
    end
    checks++;
    if (seen_valid || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_effect: valid_seen=%0d error=%b, required 0 and 0", seen_valid, rx_error);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes = '{8'hFF, 8'h00, 8'h81};
    rx_ready = 1'b1;
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
    foreach (bytes[i]) send_frame(bytes[i], 1'b1, 1'b1);
    tick(40);
    checks++;
    if (exp_q.size() != 0 || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: pending=%0d error=%b, required 0 and 0", exp_q.size(), rx_error);
    end
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: valid=%b data=%02h error=%b, required 1 3c 0", rx_valid, rx_data, rx_error);
    end
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(2);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_error !== 1'b1) begin
      errors++;
      $display("FAIL overrun_second: valid=%b data=%02h error=%b, required 1 3c 1", rx_valid, rx_data, rx_error);
    end
    rx_ready = 1'b1;
    tick(5);
    checks++;
    if (rx_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_drain: valid=%b pending=%0d, required 0 and 0", rx_valid, exp_q.size());
    end
  endtask

  task automatic test_framing;
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(40 * CPB);
    checks++;
    if (rx_busy !== 1'b1 || rx_error !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL break_hold: busy=%b error=%b valid=%b, required 1 1 0", rx_busy, rx_error, rx_valid);
    end
    rxd = 1'b1;
    tick(5);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL break_release: busy=%b, required 0", rx_busy);
    end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (exp_q.size() != 0 || rx_error !== 1'b1) begin
      errors++;
      $display("FAIL after_break: pending=%0d error=%b, required 0 and 1", exp_q.size(), rx_error);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'hB4;
    rx_ready = 1'b1;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = b[4];
    tick(HALF);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy: got %b, required 1", rx_busy);
    end
    #2 arstn = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_busy, rx_error} !== 11'h0) begin
      errors++;
      $display("FAIL async_reset: got %03h, required 000", {rx_data, rx_valid, rx_busy, rx_error});
    end
    rxd = 1'b1;
    tick(3);
    arstn = 1'b1;
    tick(5);
    exp_q.push_back(8'h6E);
    send_frame(8'h6E, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (exp_q.size() != 0 || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_frame: pending=%0d error=%b, required 0 and 0", exp_q.size(), rx_error);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
